// File: rtl/arb_pkg.sv
// Shared definitions for the fixed-priority arbiter and its requester agents.
package arb_pkg;

  localparam int NUM_REQ    = 4;
  localparam int BUS_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    GAP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/arb_req_timer.sv
// Loadable down-counter that stops at zero. The requester uses it to time
// the req-low gap after a burst.
module arb_req_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/arb_requester.sv
// Requester agent: takes a burst command, requests the bus, streams len+1
// beats while granted, then holds req low for a minimum gap.
module arb_requester
  import arb_pkg::*;
#(
  parameter int DATA_W     = BUS_DATA_W,
  parameter int LEN_W      = 4,
  parameter int TO_W       = 8,
  parameter int TIMEOUT    = 255,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              cmd_ready,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              req,
  input  logic              gnt,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_last,
  output logic              busy,
  output logic              timeout_err,
  output logic              gnt_lost
);

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  arb_state_e        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              req_q, req_d;
  logic              bus_valid_q, bus_valid_d;
  logic [DATA_W-1:0] bus_data_q, bus_data_d;
  logic              bus_last_q, bus_last_d;
  logic              timeout_err_q, timeout_err_d;
  logic              gnt_lost_q, gnt_lost_d;
  logic              gap_load;
  logic              gap_zero;
  logic              accept;
  logic [TO_W-1:0]   to_inc;

  arb_req_timer #(.W(8)) u_gap_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val (8'(GAP_CYCLES)),
    .zero     (gap_zero)
  );

  assign cmd_ready = (state_q == IDLE) & ~reset;
  assign src_ready = (state_q == XFER) & gnt & ~reset;
  assign accept    = src_valid & src_ready;
  // Saturating increment keeps the counter from wrapping when TIMEOUT is 0.
  assign to_inc    = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    beat_cnt_d    = beat_cnt_q;
    to_cnt_d      = to_cnt_q;
    req_d         = req_q;
    bus_valid_d   = 1'b0;
    bus_data_d    = bus_data_q;
    bus_last_d    = 1'b0;
    timeout_err_d = 1'b0;
    gnt_lost_d    = 1'b0;
    gap_load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          len_d      = cmd_len;
          beat_cnt_d = '0;
          to_cnt_d   = '0;
          req_d      = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (gnt) begin
          state_d = XFER;
        end else begin
          to_cnt_d = to_inc;
          if (TIMEOUT != 0 && to_inc == TO_LIM) begin
            state_d       = GAP;
            req_d         = 1'b0;
            timeout_err_d = 1'b1;
            gap_load      = 1'b1;
          end
        end
      end
      XFER: begin
        if (!gnt) begin
          state_d    = GAP;
          req_d      = 1'b0;
          gnt_lost_d = 1'b1;
          gap_load   = 1'b1;
        end else if (accept) begin
          bus_valid_d = 1'b1;
          bus_data_d  = src_data;
          bus_last_d  = (beat_cnt_q == len_q);
          if (beat_cnt_q == len_q) begin
            state_d  = GAP;
            req_d    = 1'b0;
            gap_load = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      GAP: begin
        // Wait out the stale grant so the arbiter sees us idle.
        if (gap_zero && !gnt) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      len_q         <= '0;
      beat_cnt_q    <= '0;
      to_cnt_q      <= '0;
      req_q         <= 1'b0;
      bus_valid_q   <= 1'b0;
      bus_data_q    <= '0;
      bus_last_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      gnt_lost_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      beat_cnt_q    <= beat_cnt_d;
      to_cnt_q      <= to_cnt_d;
      req_q         <= req_d;
      bus_valid_q   <= bus_valid_d;
      bus_data_q    <= bus_data_d;
      bus_last_q    <= bus_last_d;
      timeout_err_q <= timeout_err_d;
      gnt_lost_q    <= gnt_lost_d;
    end
  end

  assign req         = req_q;
  assign bus_valid   = bus_valid_q;
  assign bus_data    = bus_data_q;
  assign bus_last    = bus_last_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = timeout_err_q;
  assign gnt_lost    = gnt_lost_q;

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: directed scenarios with literal expectations, then
// random traffic, all compared every cycle against a behavioural model.
module tb_arb_requester;

  localparam int TMO  = 8;
  localparam int GAPC = 2;

  localparam int P_IDLE = 0;
  localparam int P_WAIT = 1;
  localparam int P_MOVE = 2;
  localparam int P_COOL = 3;

  logic       clk = 1'b0;
  logic       reset, cmd_valid, src_valid, gnt;
  logic [3:0] cmd_len;
  logic [7:0] src_data;
  logic       cmd_ready, src_ready, req, bus_valid, bus_last, busy, timeout_err, gnt_lost;
  logic [7:0] bus_data;

  always #5 clk = ~clk;

  arb_requester #(
    .DATA_W(8), .LEN_W(4), .TO_W(8), .TIMEOUT(TMO), .GAP_CYCLES(GAPC)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .req(req), .gnt(gnt),
    .bus_valid(bus_valid), .bus_data(bus_data), .bus_last(bus_last),
    .busy(busy), .timeout_err(timeout_err), .gnt_lost(gnt_lost)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: what the agent is doing, in plain integers.
  int         m_phase, m_len, m_sent, m_waited, m_cool;
  bit         m_req, m_bv, m_bl, m_terr, m_glost;
  logic [7:0] m_bd;

  logic [7:0] seen_d[$];
  bit         seen_l[$];
  bit         last_req;
  int         req_hi_cnt, terr_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit cv, input logic [3:0] cl,
                            input bit sv, input logic [7:0] sd, input bit g);
    m_bv = 0; m_bl = 0; m_terr = 0; m_glost = 0;
    if (r) begin
      m_phase = P_IDLE; m_req = 0; m_bd = 8'h00;
      m_sent = 0; m_waited = 0; m_cool = 0; m_len = 0;
      return;
    end
    case (m_phase)
      P_IDLE: if (cv) begin
        m_len = int'(cl); m_sent = 0; m_waited = 0; m_req = 1; m_phase = P_WAIT;
      end
      P_WAIT: if (g) m_phase = P_MOVE;
      else begin
        m_waited++;
        if (m_waited == TMO) begin
          m_phase = P_COOL; m_cool = GAPC; m_req = 0; m_terr = 1;
        end
      end
      P_MOVE: if (!g) begin
        m_phase = P_COOL; m_cool = GAPC; m_req = 0; m_glost = 1;
      end else if (sv) begin
        m_bv = 1; m_bd = sd; m_bl = (m_sent == m_len);
        if (m_bl) begin
          m_phase = P_COOL; m_cool = GAPC; m_req = 0;
        end
        m_sent++;
      end
      default: if (m_cool == 0 && !g) m_phase = P_IDLE;
      else if (m_cool > 0) m_cool--;
    endcase
  endtask

  // One clock: compare registered outputs, drive inputs, compare the
  // combinational handshakes, then advance the model past the next edge.
  task automatic cycle(input bit r, input bit cv, input logic [3:0] cl,
                       input bit sv, input logic [7:0] sd, input bit g);
    @(negedge clk);
    chk("req", req, m_req);
    chk("bus_valid", bus_valid, m_bv);
    chk("bus_data", bus_data, m_bd);
    chk("bus_last", bus_last, m_bl);
    chk("busy", busy, m_phase != P_IDLE);
    chk("timeout_err", timeout_err, m_terr);
    chk("gnt_lost", gnt_lost, m_glost);
    if (bus_valid) begin
      seen_d.push_back(bus_data);
      seen_l.push_back(bus_last);
      if (bus_last) last_req = req;
    end
    if (req) req_hi_cnt++;
    if (timeout_err) terr_cnt++;
    reset = r; cmd_valid = cv; cmd_len = cl; src_valid = sv; src_data = sd; gnt = g;
    #1;
    chk("cmd_ready", cmd_ready, m_phase == P_IDLE && !r);
    chk("src_ready", src_ready, m_phase == P_MOVE && g && !r);
    model_step(r, cv, cl, sv, sd, g);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         k;
    bit         acc, g_next, seen_high;
    int         low_run;
    logic [7:0] exp_d;

    reset = 1; cmd_valid = 1; cmd_len = 4'd3; src_valid = 0; src_data = 8'h00; gnt = 0;
    repeat (2) @(posedge clk);
    model_step(1, 1, 4'd3, 0, 8'h00, 0);

    // Reset held with a command offered: nothing may start.
    repeat (3) cycle(1, 1, 4'd3, 0, 8'h00, 0);
    chk("rst_req", req, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    cycle(0, 0, 4'd0, 0, 8'h00, 0);
    chk("rel_cmd_ready", cmd_ready, 1);

    // Four-beat burst, grant two cycles after req.
    seen_d.delete(); seen_l.delete(); last_req = 1;
    cycle(0, 1, 4'd3, 0, 8'h00, 0);
    repeat (2) cycle(0, 0, 4'd0, 0, 8'h00, 0);
    k = 0;
    for (int i = 0; i < 14; i++) begin
      acc = (m_phase == P_MOVE) && m_req;
      cycle(0, 0, 4'd0, 1, 8'hA0 + 8'(k), m_req);
      if (acc) k++;
    end
    chk("burst_beats", seen_d.size(), 4);
    for (int i = 0; i < 4; i++) begin
      exp_d = 8'hA0 + 8'(i);
      if (i < seen_d.size()) begin
        chk("burst_data", seen_d[i], exp_d);
        chk("burst_last", seen_l[i], i == 3);
      end
    end
    chk("req_at_last", last_req, 0);
    chk("burst_idle", busy, 0);

    // Grant never arrives: req high exactly TMO cycles, one error pulse.
    req_hi_cnt = 0; terr_cnt = 0;
    cycle(0, 1, 4'd5, 0, 8'h00, 0);
    repeat (14) cycle(0, 0, 4'd0, 0, 8'h00, 0);
    chk("timeout_req_cycles", req_hi_cnt, TMO);
    chk("timeout_pulses", terr_cnt, 1);
    chk("timeout_idle", busy, 0);

    // Back-to-back single-beat bursts, grant lagging req by one cycle:
    // req falls, GAPC countdown, stale grant clears, then re-request.
    g_next = 0; seen_high = 0; low_run = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(0, 1, 4'd0, 1, 8'($urandom), g_next);
      g_next = req;
      if (req) begin
        if (seen_high && low_run > 0) chk("gap_len", low_run, 4);
        seen_high = 1; low_run = 0;
      end else if (seen_high) begin
        low_run++;
      end
    end

    // Random traffic, including grant loss and mid-burst resets.
    for (int i = 0; i < 2500; i++) begin
      bit r, g;
      r = ($urandom % 300) == 0;
      if (m_phase == P_MOVE)      g = ($urandom % 100) < 95;
      else if (m_phase == P_WAIT) g = ($urandom % 100) < 30;
      else                        g = ($urandom % 100) < 35;
      cycle(r, 1'($urandom % 2), 4'($urandom), ($urandom % 100) < 75, 8'($urandom), g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
